// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared encodings for the sequential ALU/MDU execute unit
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SLT  = 4'b0101,
        ALU_SLTU = 4'b0110,
        ALU_SLL  = 4'b0111,
        ALU_SRL  = 4'b1000,
        ALU_SRA  = 4'b1001,
        ALU_MDU  = 4'b1010
    } alu_ctrl_t;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ALU_DONE = 3'd1,
        S_MUL      = 3'd2,
        S_DIV      = 3'd3,
        S_FIXUP    = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    localparam logic [2:0] F3_ADDSUB = 3'b000;
    localparam logic [2:0] F3_SLL    = 3'b001;
    localparam logic [2:0] F3_SLT    = 3'b010;
    localparam logic [2:0] F3_SLTU   = 3'b011;
    localparam logic [2:0] F3_XOR    = 3'b100;
    localparam logic [2:0] F3_SR     = 3'b101;
    localparam logic [2:0] F3_OR     = 3'b110;
    localparam logic [2:0] F3_AND    = 3'b111;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_RSVD  = 2'b11;

endpackage

// File: rtl/alu_exec_seq_if.sv
// rtl/alu_exec_seq_if.sv - request/response bundle of the execute unit
interface alu_exec_seq_if #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 4
);
    logic              valid_i;
    logic              opb5;
    logic [2:0]        funct3;
    logic              funct7b5;
    logic              funct7b0;
    logic [1:0]        ALUOp;
    logic [XLEN-1:0]   srca;
    logic [XLEN-1:0]   srcb;
    logic              ready_o;
    logic              done_o;
    logic [XLEN-1:0]   result_o;
    logic [CTRL_W-1:0] alu_ctrl_o;
    logic              illegal_o;

    modport master (
        output valid_i, opb5, funct3, funct7b5, funct7b0, ALUOp, srca, srcb,
        input  ready_o, done_o, result_o, alu_ctrl_o, illegal_o
    );

    modport slave (
        input  valid_i, opb5, funct3, funct7b5, funct7b0, ALUOp, srca, srcb,
        output ready_o, done_o, result_o, alu_ctrl_o, illegal_o
    );
endinterface

// File: rtl/aludec_ext.sv
// rtl/aludec_ext.sv - combinational ALU control decoder (M ops when RV32M_EN is defined)
module aludec_ext
    import alu_pkg::*;
(
    input  logic [1:0] ALUOp,
    input  logic       opb5,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       funct7b0,
    output alu_ctrl_t  alu_ctrl,
    output logic       illegal,
    output logic       mdu_sel
);
    // Map instruction fields to an ALU control, flagging reserved or unsupported encodings
    always_comb begin
        alu_ctrl = ALU_ADD;
        illegal  = 1'b0;
        mdu_sel  = 1'b0;
        case (ALUOp)
            ALUOP_ADD: alu_ctrl = ALU_ADD;
            ALUOP_SUB: alu_ctrl = ALU_SUB;
            ALUOP_FUNCT: begin
                if (opb5 && funct7b0) begin
`ifdef RV32M_EN
                    alu_ctrl = ALU_MDU;
                    mdu_sel  = 1'b1;
`else
                    illegal  = 1'b1;
`endif
                end else begin
                    case (funct3)
                        F3_ADDSUB: alu_ctrl = (opb5 && funct7b5) ? ALU_SUB : ALU_ADD;
                        F3_SLL:    alu_ctrl = ALU_SLL;
                        F3_SLT:    alu_ctrl = ALU_SLT;
                        F3_SLTU:   alu_ctrl = ALU_SLTU;
                        F3_XOR:    alu_ctrl = ALU_XOR;
                        F3_SR:     alu_ctrl = funct7b5 ? ALU_SRA : ALU_SRL;
                        F3_OR:     alu_ctrl = ALU_OR;
                        default:   alu_ctrl = ALU_AND;
                    endcase
                end
            end
            default: illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/alu_exec_seq.sv
// rtl/alu_exec_seq.sv - handshaked ALU with iterative mul/div engine (macro RV32M_EN)
module alu_exec_seq
    import alu_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 4
) (
    input  logic         clk,
    input  logic         reset,
    alu_exec_seq_if.slave bus
);
    localparam int SH_W = $clog2(XLEN);

    alu_ctrl_t       dec_ctrl;
    logic            dec_illegal;
    logic            dec_mdu_sel;
    state_t          state_q, state_d, start_state;
    logic            ready, done, accept;
    logic [SH_W-1:0] shamt;
    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] result_q, result_d;
    alu_ctrl_t       alu_ctrl_q, alu_ctrl_d;
    logic            illegal_q, illegal_d;

    aludec_ext u_dec (
        .ALUOp    (bus.ALUOp),
        .opb5     (bus.opb5),
        .funct3   (bus.funct3),
        .funct7b5 (bus.funct7b5),
        .funct7b0 (bus.funct7b0),
        .alu_ctrl (dec_ctrl),
        .illegal  (dec_illegal),
        .mdu_sel  (dec_mdu_sel)
    );

    assign accept = ready && bus.valid_i;
    assign shamt  = bus.srcb[SH_W-1:0];

`ifdef RV32M_EN
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    logic [2:0]        op_q, op_d;
    logic [SH_W-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0]   p_hi_q, p_hi_d, p_lo_q, p_lo_d, mcand_q, mcand_d;
    logic              flip_main_q, flip_main_d, flip_rem_q, flip_rem_d;
    logic              a_signed, b_signed, a_neg, b_neg, div_zero, div_ovf, div_special;
    logic [XLEN-1:0]   a_mag, b_mag, mdu_res;
    logic [XLEN:0]     mul_sum, div_shift, div_diff;
    logic [2*XLEN-1:0] prod, prod_fix;

    // Operand sign handling and divide corner detection for the request on the bus
    always_comb begin
        a_signed    = (bus.funct3 == F3_MULH) || (bus.funct3 == F3_MULHSU) ||
                      (bus.funct3 == F3_DIV)  || (bus.funct3 == F3_REM);
        b_signed    = (bus.funct3 == F3_MULH) || (bus.funct3 == F3_DIV) || (bus.funct3 == F3_REM);
        a_neg       = a_signed && bus.srca[XLEN-1];
        b_neg       = b_signed && bus.srcb[XLEN-1];
        a_mag       = a_neg ? -bus.srca : bus.srca;
        b_mag       = b_neg ? -bus.srcb : bus.srcb;
        div_zero    = (bus.srcb == '0);
        div_ovf     = b_signed && (bus.srca == MIN_NEG) && (bus.srcb == '1);
        div_special = div_zero || div_ovf;
    end

    // Iterative engine: load magnitudes on accept, one shift-add or restoring step per cycle
    always_comb begin
        op_d        = op_q;
        cnt_d       = cnt_q;
        p_hi_d      = p_hi_q;
        p_lo_d      = p_lo_q;
        mcand_d     = mcand_q;
        flip_main_d = flip_main_q;
        flip_rem_d  = flip_rem_q;
        mul_sum     = {1'b0, p_hi_q} + (p_lo_q[0] ? {1'b0, mcand_q} : '0);
        div_shift   = {p_hi_q, p_lo_q[XLEN-1]};
        div_diff    = div_shift - {1'b0, mcand_q};
        prod        = {p_hi_q, p_lo_q};
        prod_fix    = flip_main_q ? -prod : prod;
        mdu_res     = '0;
        case (op_q)
            F3_MUL:                       mdu_res = prod_fix[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: mdu_res = prod_fix[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:              mdu_res = flip_main_q ? -p_lo_q : p_lo_q;
            default:                      mdu_res = flip_rem_q ? -p_hi_q : p_hi_q;
        endcase
        if (accept && dec_mdu_sel) begin
            op_d        = bus.funct3;
            cnt_d       = SH_W'(XLEN - 1);
            flip_main_d = a_neg ^ b_neg;
            flip_rem_d  = a_neg;
            p_hi_d      = '0;
            p_lo_d      = a_mag;
            mcand_d     = b_mag;
            if (!bus.funct3[2]) begin
                p_lo_d  = b_mag;
                mcand_d = a_mag;
            end else if (div_zero) begin
                // quotient all ones, remainder is the dividend, no sign correction
                p_lo_d      = '1;
                p_hi_d      = bus.srca;
                flip_main_d = 1'b0;
                flip_rem_d  = 1'b0;
            end else if (div_ovf) begin
                p_lo_d      = bus.srca;
                flip_main_d = 1'b0;
                flip_rem_d  = 1'b0;
            end
        end else if (state_q == S_MUL) begin
            p_hi_d = mul_sum[XLEN:1];
            p_lo_d = {mul_sum[0], p_lo_q[XLEN-1:1]};
            cnt_d  = cnt_q - SH_W'(1);
        end else if (state_q == S_DIV) begin
            if (!div_diff[XLEN]) begin
                p_hi_d = div_diff[XLEN-1:0];
                p_lo_d = {p_lo_q[XLEN-2:0], 1'b1};
            end else begin
                p_hi_d = div_shift[XLEN-1:0];
                p_lo_d = {p_lo_q[XLEN-2:0], 1'b0};
            end
            cnt_d = cnt_q - SH_W'(1);
        end
    end

    // Engine registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q        <= '0;
            cnt_q       <= '0;
            p_hi_q      <= '0;
            p_lo_q      <= '0;
            mcand_q     <= '0;
            flip_main_q <= 1'b0;
            flip_rem_q  <= 1'b0;
        end else begin
            op_q        <= op_d;
            cnt_q       <= cnt_d;
            p_hi_q      <= p_hi_d;
            p_lo_q      <= p_lo_d;
            mcand_q     <= mcand_d;
            flip_main_q <= flip_main_d;
            flip_rem_q  <= flip_rem_d;
        end
    end
`endif

    // Single-cycle ALU result computed from the request, captured on accept
    always_comb begin
        alu_res = '0;
        case (dec_ctrl)
            ALU_ADD:  alu_res = bus.srca + bus.srcb;
            ALU_SUB:  alu_res = bus.srca - bus.srcb;
            ALU_AND:  alu_res = bus.srca & bus.srcb;
            ALU_OR:   alu_res = bus.srca | bus.srcb;
            ALU_XOR:  alu_res = bus.srca ^ bus.srcb;
            ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(bus.srca) < $signed(bus.srcb)};
            ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, bus.srca < bus.srcb};
            ALU_SLL:  alu_res = bus.srca << shamt;
            ALU_SRL:  alu_res = bus.srca >> shamt;
            ALU_SRA:  alu_res = $signed(bus.srca) >>> shamt;
            default:  alu_res = '0;
        endcase
        if (dec_illegal) alu_res = '0;
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // FSM next state: pick the path on accept, count iterations, then fix up and finish
    always_comb begin
        start_state = S_ALU_DONE;
`ifdef RV32M_EN
        if (dec_mdu_sel) begin
            if (!bus.funct3[2])   start_state = S_MUL;
            else if (div_special) start_state = S_FIXUP;
            else                  start_state = S_DIV;
        end
`endif
        state_d = state_q;
        case (state_q)
            S_IDLE, S_ALU_DONE, S_DONE: state_d = accept ? start_state : S_IDLE;
`ifdef RV32M_EN
            S_MUL, S_DIV: if (cnt_q == '0) state_d = S_FIXUP;
            S_FIXUP:      state_d = S_DONE;
`endif
            default:      state_d = S_IDLE;
        endcase
    end

    // FSM outputs: ready again on the done cycle so back-to-back requests are taken
    always_comb begin
        ready = 1'b0;
        done  = 1'b0;
        case (state_q)
            S_IDLE: ready = 1'b1;
            S_ALU_DONE, S_DONE: begin
                ready = 1'b1;
                done  = 1'b1;
            end
            default: ;
        endcase
    end

    // Result/control capture: ALU path on accept, MDU path in FIXUP
    always_comb begin
        result_d   = result_q;
        alu_ctrl_d = alu_ctrl_q;
        illegal_d  = illegal_q;
        if (accept) begin
            alu_ctrl_d = dec_ctrl;
            illegal_d  = dec_illegal;
            if (!dec_mdu_sel) result_d = alu_res;
        end
`ifdef RV32M_EN
        if (state_q == S_FIXUP) result_d = mdu_res;
`endif
    end

    // Output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_q   <= '0;
            alu_ctrl_q <= ALU_ADD;
            illegal_q  <= 1'b0;
        end else begin
            result_q   <= result_d;
            alu_ctrl_q <= alu_ctrl_d;
            illegal_q  <= illegal_d;
        end
    end

    assign bus.ready_o    = ready;
    assign bus.done_o     = done;
    assign bus.result_o   = result_q;
    assign bus.alu_ctrl_o = CTRL_W'(alu_ctrl_q);
    assign bus.illegal_o  = illegal_q;
endmodule

// File: tb/tb_alu_exec_seq.sv
// tb/tb_alu_exec_seq.sv - self-checking bench for alu_exec_seq (honours RV32M_EN)
module tb_alu_exec_seq;
    localparam int XLEN = 32;

    typedef struct packed {
        logic [31:0] res;
        logic [3:0]  ctrl;
        logic        ill;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    alu_exec_seq_if #(.XLEN(XLEN), .CTRL_W(4)) bus ();

    alu_exec_seq #(.XLEN(XLEN), .CTRL_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [1:0] aluop, input logic opb5, input logic [2:0] f3,
                                   input logic f7b5, input logic f7b0,
                                   input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        longint sa, sb;
        longint unsigned ua, ub;
        int sh;
        sa = $signed(a);
        sb = $signed(b);
        ua = 64'(a);
        ub = 64'(b);
        sh = int'(b[4:0]);
        e.res = 32'd0; e.ctrl = 4'd0; e.ill = 1'b0; e.lat = 1;
        if (aluop == 2'b11) begin
            e.ill = 1'b1;
            return e;
        end
        if (aluop == 2'b00) begin
            e.res = a + b;
            return e;
        end
        if (aluop == 2'b01) begin
            e.res = a - b; e.ctrl = 4'b0001;
            return e;
        end
        if (opb5 && f7b0) begin
`ifdef RV32M_EN
            e.ctrl = 4'b1010;
            e.lat  = XLEN + 2;
            case (f3)
                3'd0: e.res = 32'(ua * ub);
                3'd1: e.res = 32'((sa * sb) >>> 32);
                3'd2: e.res = 32'((sa * longint'(ub)) >>> 32);
                3'd3: e.res = 32'((ua * ub) >> 32);
                3'd4: if (b == 0) begin e.res = 32'hFFFF_FFFF; e.lat = 2; end
                      else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin e.res = a; e.lat = 2; end
                      else e.res = 32'(sa / sb);
                3'd5: if (b == 0) begin e.res = 32'hFFFF_FFFF; e.lat = 2; end
                      else e.res = a / b;
                3'd6: if (b == 0) begin e.res = a; e.lat = 2; end
                      else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin e.res = 0; e.lat = 2; end
                      else e.res = 32'(sa % sb);
                default: if (b == 0) begin e.res = a; e.lat = 2; end
                         else e.res = a % b;
            endcase
`else
            e.ill = 1'b1;
`endif
            return e;
        end
        case (f3)
            3'd0: if (opb5 && f7b5) begin e.res = a - b; e.ctrl = 4'b0001; end
                  else e.res = a + b;
            3'd1: begin e.res = a << sh; e.ctrl = 4'b0111; end
            3'd2: begin e.res = (sa < sb) ? 32'd1 : 32'd0; e.ctrl = 4'b0101; end
            3'd3: begin e.res = (a < b) ? 32'd1 : 32'd0; e.ctrl = 4'b0110; end
            3'd4: begin e.res = a ^ b; e.ctrl = 4'b0100; end
            3'd5: if (f7b5) begin e.res = 32'(sa >>> sh); e.ctrl = 4'b1001; end
                  else begin e.res = a >> sh; e.ctrl = 4'b1000; end
            3'd6: begin e.res = a | b; e.ctrl = 4'b0011; end
            default: begin e.res = a & b; e.ctrl = 4'b0010; end
        endcase
        return e;
    endfunction

    task automatic drive(input logic [1:0] aluop, input logic opb5, input logic [2:0] f3,
                         input logic f7b5, input logic f7b0, input logic [31:0] a, input logic [31:0] b);
        bus.ALUOp = aluop; bus.opb5 = opb5; bus.funct3 = f3;
        bus.funct7b5 = f7b5; bus.funct7b0 = f7b0;
        bus.srca = a; bus.srcb = b; bus.valid_i = 1'b1;
    endtask

    // Starts at a negedge, returns at the negedge where done_o is seen (or the budget expires)
    task automatic run_op(input string tag, input logic [1:0] aluop, input logic opb5, input logic [2:0] f3,
                          input logic f7b5, input logic f7b0, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int cyc;
        e = model(aluop, opb5, f3, f7b5, f7b0, a, b);
        check({tag, "_ready"}, 64'(bus.ready_o), 64'd1);
        drive(aluop, opb5, f3, f7b5, f7b0, a, b);
        @(posedge clk);
        cyc = 0;
        while (1) begin
            @(negedge clk);
            bus.valid_i = 1'b0;
            cyc++;
            if (cyc == 1 && e.lat > 1) check({tag, "_busy"}, 64'(bus.ready_o), 64'd0);
            if (bus.done_o === 1'b1 || cyc >= 200) break;
        end
        check({tag, "_lat"}, 64'(cyc), 64'(e.lat));
        check({tag, "_res"}, 64'(bus.result_o), 64'(e.res));
        check({tag, "_ill"}, 64'(bus.illegal_o), 64'(e.ill));
        if (!e.ill) check({tag, "_ctrl"}, 64'(bus.alu_ctrl_o), 64'(e.ctrl));
    endtask

    logic [31:0] corners [6];

    initial begin
        corners[0] = 32'h0;         corners[1] = 32'hFFFF_FFFF;
        corners[2] = 32'h8000_0000; corners[3] = 32'h7FFF_FFFF;
        corners[4] = 32'h1;         corners[5] = 32'h2;
        reset = 1'b1;
        drive(2'b00, 1'b0, 3'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        bus.valid_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_ready", 64'(bus.ready_o), 64'd1);
        check("rst_done", 64'(bus.done_o), 64'd0);
        check("rst_result", 64'(bus.result_o), 64'd0);
        check("rst_ctrl", 64'(bus.alu_ctrl_o), 64'd0);
        check("rst_ill", 64'(bus.illegal_o), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        run_op("sub", 2'b10, 1'b1, 3'd0, 1'b1, 1'b0, 32'd5, 32'd7);
        check("sub_val", 64'(bus.result_o), 64'hFFFF_FFFE);
        @(negedge clk);
        check("done_pulse", 64'(bus.done_o), 64'd0);
        check("result_hold", 64'(bus.result_o), 64'hFFFF_FFFE);

        run_op("sra", 2'b10, 1'b1, 3'd5, 1'b1, 1'b0, 32'h8000_0000, 32'd4);
        check("sra_val", 64'(bus.result_o), 64'hF800_0000);
        run_op("srl", 2'b10, 1'b1, 3'd5, 1'b0, 1'b0, 32'h8000_0000, 32'd4);
        check("srl_val", 64'(bus.result_o), 64'h0800_0000);
        run_op("sll_lowbits", 2'b10, 1'b1, 3'd1, 1'b0, 1'b0, 32'd1, 32'h23);
        run_op("slt_neg", 2'b10, 1'b1, 3'd2, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1);
        run_op("sltu_neg", 2'b10, 1'b1, 3'd3, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1);
        run_op("rsvd", 2'b11, 1'b1, 3'd0, 1'b0, 1'b0, 32'd3, 32'd4);
        check("rsvd_res", 64'(bus.result_o), 64'd0);

        run_op("mulh", 2'b10, 1'b1, 3'd1, 1'b0, 1'b1, 32'hFFFF_FFFE, 32'd3);
        run_op("mul", 2'b10, 1'b1, 3'd0, 1'b0, 1'b1, 32'hFFFF_FFFE, 32'd3);
        run_op("div0", 2'b10, 1'b1, 3'd4, 1'b0, 1'b1, 32'd9, 32'd0);
        run_op("rem_ovf", 2'b10, 1'b1, 3'd6, 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("div_ovf", 2'b10, 1'b1, 3'd4, 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("div", 2'b10, 1'b1, 3'd4, 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2);

        run_op("pre_rst", 2'b01, 1'b0, 3'd0, 1'b0, 1'b0, 32'd5, 32'd9);
`ifdef RV32M_EN
        drive(2'b10, 1'b1, 3'd0, 1'b0, 1'b1, 32'd6, 32'd7);
        @(posedge clk);
        @(negedge clk);
        bus.valid_i = 1'b0;
        repeat (9) @(negedge clk);
`else
        drive(2'b01, 1'b0, 3'd0, 1'b0, 1'b0, 32'd5, 32'd9);
        @(posedge clk);
        @(negedge clk);
        bus.valid_i = 1'b0;
`endif
        reset = 1'b1;
        #1;
        check("abort_ready", 64'(bus.ready_o), 64'd1);
        check("abort_done", 64'(bus.done_o), 64'd0);
        check("abort_result", 64'(bus.result_o), 64'd0);
        check("abort_ctrl", 64'(bus.alu_ctrl_o), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run_op("post_rst_add", 2'b00, 1'b0, 3'd0, 1'b0, 1'b0, 32'd1, 32'd2);
        check("post_rst_val", 64'(bus.result_o), 64'd3);

        for (int i = 0; i < 60; i++) begin
            logic [1:0]  aluop;
            logic [31:0] a, b;
            int sel;
            sel = $urandom_range(0, 9);
            aluop = (sel == 0) ? 2'b00 : (sel == 1) ? 2'b01 : (sel == 2) ? 2'b11 : 2'b10;
            a = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
            b = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
            run_op($sformatf("rnd%0d", i), aluop, 1'($urandom), 3'($urandom), 1'($urandom), 1'($urandom), a, b);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
